fa_serial_ctrl: RTL and testbench

Bit-serial sequencer that computes a WIDTH-bit add on one shared full_adder_core, one bit per step, LSB first. It accepts operands over a valid/ready handshake and drives the core's in_a/in_b/in_c. It samples s_out/c_out back, ripples the carry internally, and returns the assembled sum and carry-out over a second valid/ready handshake. It sits between the ALU operand registers and the full_adder_core instance.

---
 rtl/fa_serial_ctrl.sv | 178 +++++++++++++++++
 tb/tb_fa_serial_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fa_serial_ctrl.sv
// ============================================================================
// Module   : fa_serial_ctrl
// Brief    : Bit-serial WIDTH-bit adder sequencer driving one shared full-adder
//            core, LSB first. Optional subtract path under `SEQ_SUB_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fa_serial_ctrl #(
    parameter int WIDTH  = 3,
    parameter int FA_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    input  logic             i_in_cin,
`ifdef SEQ_SUB_EN
    input  logic             i_in_sub,
`endif
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_sum,
    output logic             o_out_cout,
    output logic             o_busy,
    output logic             o_fa_a,
    output logic             o_fa_b,
    output logic             o_fa_c,
    input  logic             i_fa_s,
    input  logic             i_fa_c_out
);

    localparam int              c_IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(WIDTH - 1);
    localparam logic [c_IW-1:0] c_IDX_ONE  = c_IW'(1);
    localparam logic [1:0]      c_CNT_INIT = 2'(FA_LAT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic [c_IW-1:0]  r_idx;
    logic [1:0]       r_cnt;

    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;
    logic             r_busy;
    logic             r_fa_a;
    logic             r_fa_b;
    logic             r_fa_c;

    logic             w_sub_in;
    logic             w_capture;
    logic             w_last;
    logic             w_fa_a;
    logic             w_fa_b;
    logic             w_fa_c;
    logic [WIDTH-1:0] w_sum_cap;

`ifdef SEQ_SUB_EN
    assign w_sub_in = i_in_sub;
`else
    assign w_sub_in = 1'b0;
`endif

    assign w_capture = (r_state == c_WAIT) && (r_cnt == 2'd0);
    assign w_last    = (r_idx == c_LAST_IDX);

    // State register plus all registered outputs and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_cnt       <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_busy      <= 1'b0;
            r_fa_a      <= 1'b0;
            r_fa_b      <= 1'b0;
            r_fa_c      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == c_IDLE);
            r_busy      <= (w_next != c_IDLE);
            r_out_valid <= (w_next == c_DONE);
            r_fa_a      <= w_fa_a;
            r_fa_b      <= w_fa_b;
            r_fa_c      <= w_fa_c;
            case (r_state)
                c_IDLE: begin
                    if (i_in_valid) begin
                        r_a     <= i_in_a;
                        r_b     <= i_in_b;
                        r_sub   <= w_sub_in;
                        r_carry <= w_sub_in | i_in_cin;
                        r_idx   <= '0;
                    end
                end
                c_ISSUE: r_cnt <= c_CNT_INIT;
                c_WAIT: begin
                    if (w_capture) begin
                        r_sum   <= w_sum_cap;
                        r_carry <= i_fa_c_out;
                        if (w_last) begin
                            r_out_sum  <= w_sum_cap;
                            r_out_cout <= i_fa_c_out;
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (i_in_valid) w_next = c_ISSUE;
            c_ISSUE: w_next = c_WAIT;
            c_WAIT:  if (w_capture) w_next = w_last ? c_DONE : c_ISSUE;
            c_DONE:  if (i_out_ready) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Core inputs change only on leaving ISSUE, so they are stable for the whole WAIT
    always_comb begin
        w_fa_a    = 1'b0;
        w_fa_b    = 1'b0;
        w_fa_c    = 1'b0;
        w_sum_cap = r_sum;
        w_sum_cap[r_idx] = i_fa_s;
        if (r_state == c_ISSUE) begin
            w_fa_a = r_a[r_idx];
            w_fa_b = r_b[r_idx] ^ r_sub;
            w_fa_c = r_carry;
        end else if (r_state == c_WAIT && w_next != c_DONE) begin
            w_fa_a = r_fa_a;
            w_fa_b = r_fa_b;
            w_fa_c = r_fa_c;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_out_sum;
    assign o_out_cout  = r_out_cout;
    assign o_busy      = r_busy;
    assign o_fa_a      = r_fa_a;
    assign o_fa_b      = r_fa_b;
    assign o_fa_c      = r_fa_c;

endmodule

`default_nettype wire

// File: tb/tb_fa_serial_ctrl.sv
// ============================================================================
// Module   : tb_fa_serial_ctrl
// Brief    : Directed self-checking bench for fa_serial_ctrl (3-bit/lat-1 and
//            4-bit/lat-2 instances with behavioural full-adder cores).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fa_serial_ctrl;

    logic       clk;
    logic       rst_n;
    int         cyc;
    int         checks;
    int         failures;

    logic       in_valid, in_ready, in_cin, out_valid, out_ready, cout, busy;
    logic [2:0] in_a, in_b, sum;
    logic       fa_a, fa_b, fa_c, fa_s, fa_co;
`ifdef SEQ_SUB_EN
    logic       in_sub;
`endif

    logic       in_valid4, in_ready4, out_valid4, out_ready4, cout4, busy4;
    logic [3:0] in_a4, in_b4, sum4;
    logic       fa_a4, fa_b4, fa_c4, fa_s4, fa_co4;
    logic       d4_a, d4_b, d4_c;

    logic [2:0] fa_a_trace, fa_b_trace;

    fa_serial_ctrl #(.WIDTH(3), .FA_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_a(in_a), .i_in_b(in_b), .i_in_cin(in_cin),
`ifdef SEQ_SUB_EN
        .i_in_sub(in_sub),
`endif
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_sum(sum), .o_out_cout(cout), .o_busy(busy),
        .o_fa_a(fa_a), .o_fa_b(fa_b), .o_fa_c(fa_c),
        .i_fa_s(fa_s), .i_fa_c_out(fa_co)
    );

    fa_serial_ctrl #(.WIDTH(4), .FA_LAT(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid4), .o_in_ready(in_ready4),
        .i_in_a(in_a4), .i_in_b(in_b4), .i_in_cin(1'b0),
`ifdef SEQ_SUB_EN
        .i_in_sub(1'b0),
`endif
        .o_out_valid(out_valid4), .i_out_ready(out_ready4),
        .o_out_sum(sum4), .o_out_cout(cout4), .o_busy(busy4),
        .o_fa_a(fa_a4), .o_fa_b(fa_b4), .o_fa_c(fa_c4),
        .i_fa_s(fa_s4), .i_fa_c_out(fa_co4)
    );

    // Latency-1 core settles within the cycle; latency-2 core adds one register stage
    assign fa_s  = fa_a ^ fa_b ^ fa_c;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    always @(posedge clk) begin
        d4_a <= fa_a4;
        d4_b <= fa_b4;
        d4_c <= fa_c4;
    end
    assign fa_s4  = d4_a ^ d4_b ^ d4_c;
    assign fa_co4 = (d4_a & d4_b) | (d4_a & d4_c) | (d4_b & d4_c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one operation on the 3-bit instance and check latency and result
    task automatic run_op(input logic [2:0] a_v, input logic [2:0] b_v, input logic cin_v,
                          input logic [2:0] exp_s, input logic exp_c, input string tag,
                          input bit hold);
        int lat;
        in_a     = a_v;
        in_b     = b_v;
        in_cin   = cin_v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk({tag, "_busy"}, busy, 1);
                chk({tag, "_in_ready_low"}, in_ready, 0);
            end
            if ((lat % 2) == 1 && lat <= 5) begin
                fa_a_trace[(lat - 1) / 2] = fa_a;
                fa_b_trace[(lat - 1) / 2] = fa_b;
            end
        end
        chk({tag, "_latency"}, lat, 6);
        chk({tag, "_sum"}, sum, exp_s);
        chk({tag, "_cout"}, cout, exp_c);
        if (!hold) begin
            out_ready = 1'b1;
            @(negedge clk);
            chk({tag, "_valid_drop"}, out_valid, 0);
            chk({tag, "_ready_back"}, in_ready, 1);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        int  n;
        int  t0;
        bit  seen;
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_cin     = 1'b0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        in_a4      = '0;
        in_b4      = '0;
        out_ready4 = 1'b0;
        fa_a_trace = '0;
        fa_b_trace = '0;
`ifdef SEQ_SUB_EN
        in_sub     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fa", {fa_a, fa_b, fa_c}, 0);
        chk("rst_sum_cout", {sum, cout}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd3, 3'd5, 1'b0, 3'b000, 1'b1, "add3p5", 0);
        chk("add3p5_fa_a_seq", fa_a_trace, 3'b011);
        chk("add3p5_fa_b_seq", fa_b_trace, 3'b101);
        run_op(3'd7, 3'd7, 1'b1, 3'b111, 1'b1, "add7p7c", 0);
        run_op(3'd2, 3'd1, 1'b0, 3'b011, 1'b0, "add2p1", 0);

        run_op(3'd2, 3'd1, 1'b0, 3'b011, 1'b0, "bp", 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", out_valid, 1);
            chk("bp_sum_hold", {sum, cout}, {3'b011, 1'b0});
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", out_valid, 0);
        out_ready = 1'b0;

        // Reset during WAIT of bit 1
        in_a     = 3'd6;
        in_b     = 3'd3;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_fa_bit1", {fa_a, fa_b, fa_c}, 3'b110);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", in_ready, 1);
        chk("async_rst_outs", {out_valid, busy, fa_a, fa_b, fa_c, sum, cout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rst_no_valid", seen, 0);
        chk("rst_idle_ready", in_ready, 1);

        // Back-to-back with in_valid and out_ready held high
        in_a      = 3'd1;
        in_b      = 3'd1;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        t0 = cyc;
        @(negedge clk);
        in_a = 3'd7;
        in_b = 3'd7;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_res0", {sum, cout}, {3'b010, 1'b0});
        @(negedge clk);
        chk("b2b_one_cycle", out_valid, 0);
        chk("b2b_ready", in_ready, 1);
        chk("b2b_interval", cyc - t0, 8);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 3'd0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_res1", {sum, cout}, {3'b110, 1'b1});
        @(negedge clk);
        chk("b2b_done", out_valid, 0);
        out_ready = 1'b0;

`ifdef SEQ_SUB_EN
        in_sub = 1'b1;
        run_op(3'd5, 3'd3, 1'b0, 3'b010, 1'b1, "sub5m3", 0);
        run_op(3'd3, 3'd5, 1'b0, 3'b110, 1'b0, "sub3m5", 0);
        in_sub = 1'b0;
`endif

        // Wider, slower instance
        in_a4     = 4'd9;
        in_b4     = 4'd8;
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("w4_latency", n, 12);
        chk("w4_sum", sum4, 4'b0001);
        chk("w4_cout", cout4, 1);
        out_ready4 = 1'b1;
        @(negedge clk);
        chk("w4_valid_drop", out_valid4, 0);
        out_ready4 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
